fpcvt_pipe: RTL and testbench

//  Pipelined, parametrised two's-complement integer -> sign/exponent/mantissa float converter.

---
 rtl/fpcvt_pkg.sv | 37 +++
 rtl/fpcvt_lzc.sv | 20 ++
 rtl/fpcvt_pipe.sv | 151 +++++++++++++++
 tb/tb_fpcvt_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpcvt_pkg.sv
// Shared widths and stage-record types for the integer-to-float converter and its packing logic.
package fpcvt_pkg;

    localparam int DEF_IN_W  = 12;
    localparam int DEF_EXP_W = 3;
    localparam int DEF_MAN_W = 4;
    localparam int DEF_E_MAX = 2**DEF_EXP_W - 1;
    localparam int DEF_K     = DEF_IN_W - DEF_MAN_W;
    localparam int DEF_LZ_W  = $clog2(DEF_IN_W + 1);

    typedef struct packed {
        logic                  s;
        logic                  special;
        logic [DEF_IN_W-1:0]   mag;
    } s1_t;

    // Exponent carries one spare bit so rounding overflow is visible before the clamp
    typedef struct packed {
        logic                  s;
        logic                  special;
        logic [DEF_EXP_W:0]    e;
        logic [DEF_MAN_W-1:0]  f;
        logic                  rbit;
    } s2_t;

    typedef struct packed {
        logic                  s;
        logic [DEF_EXP_W-1:0]  e;
        logic [DEF_MAN_W-1:0]  f;
        logic                  sat;
    } result_t;

    function automatic int e_max(input int exp_w);
        return 2**exp_w - 1;
    endfunction

endpackage

// File: rtl/fpcvt_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fpcvt_lzc #(
    parameter int W    = 12,
    parameter int LZ_W = $clog2(W + 1)
) (
    input  logic [W-1:0]    value,
    output logic [LZ_W-1:0] lz
);

    // Scanning upward lets the highest set bit have the final say
    always_comb begin
        lz = LZ_W'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                lz = LZ_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage two's-complement integer to sign/exponent/mantissa converter with valid/ready flow control.
// Define FPCVT_ROUND_EN to round the mantissa half-up; otherwise it is truncated.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_s,
    output logic [EXP_W-1:0] out_e,
    output logic [MAN_W-1:0] out_f,
    output logic             out_sat
);

    localparam int              E_MAX    = e_max(EXP_W);
    localparam int              K        = IN_W - MAN_W;
    localparam int              LZ_W     = $clog2(IN_W + 1);
    localparam logic [EXP_W:0]  E_MAX_X  = (EXP_W+1)'(E_MAX);
    localparam logic [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [MAN_W-1:0] F_ONES  = '1;

    logic adv;

    logic             v1, s1_s, s1_special;
    logic [IN_W-1:0]  s1_mag;

    logic [LZ_W-1:0]  lz;
    logic [EXP_W:0]   e2_n;
    logic [MAN_W-1:0] f2_n;
    logic             v2, s2_s, s2_special;
    logic [EXP_W:0]   s2_e;
    logic [MAN_W-1:0] s2_f;
`ifdef FPCVT_ROUND_EN
    logic             r2_n, s2_r;
    localparam logic [MAN_W-1:0] F_HALF = {1'b1, {(MAN_W-1){1'b0}}};
`endif

    logic [EXP_W:0]   e3_n;
    logic [MAN_W-1:0] f3_n;
    logic             sat3_n;

    // Global enable: the whole pipe moves together, so bubbles are kept
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            s1_s       <= 1'b0;
            s1_special <= 1'b0;
            s1_mag     <= '0;
        end else if (adv) begin
            v1         <= in_valid;
            s1_s       <= in_data[IN_W-1];
            s1_special <= (in_data == MOST_NEG);
            s1_mag     <= in_data[IN_W-1] ? -in_data : in_data;
        end
    end

    fpcvt_lzc #(
        .W    (IN_W),
        .LZ_W (LZ_W)
    ) u_lzc (
        .value (s1_mag),
        .lz    (lz)
    );

    // Small magnitudes fit the mantissa exactly and stay denormal with E = 0
    always_comb begin
        e2_n = '0;
        f2_n = s1_mag[MAN_W-1:0];
`ifdef FPCVT_ROUND_EN
        r2_n = 1'b0;
`endif
        if (int'(lz) < K) begin
            e2_n = (EXP_W+1)'(K - int'(lz));
            f2_n = MAN_W'((s1_mag << lz) >> (IN_W - MAN_W));
`ifdef FPCVT_ROUND_EN
            r2_n = 1'((s1_mag << lz) >> (IN_W - 1 - MAN_W));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2         <= 1'b0;
            s2_s       <= 1'b0;
            s2_special <= 1'b0;
            s2_e       <= '0;
            s2_f       <= '0;
`ifdef FPCVT_ROUND_EN
            s2_r       <= 1'b0;
`endif
        end else if (adv) begin
            v2         <= v1;
            s2_s       <= s1_s;
            s2_special <= s1_special;
            s2_e       <= e2_n;
            s2_f       <= f2_n;
`ifdef FPCVT_ROUND_EN
            s2_r       <= r2_n;
`endif
        end
    end

    always_comb begin
        e3_n   = s2_e;
        f3_n   = s2_f;
        sat3_n = 1'b0;
`ifdef FPCVT_ROUND_EN
        if (s2_r) begin
            if (s2_f != F_ONES) begin
                f3_n = s2_f + MAN_W'(1);
            end else begin
                f3_n = F_HALF;
                e3_n = s2_e + (EXP_W+1)'(1);
            end
        end
`endif
        if (s2_special || (e3_n > E_MAX_X)) begin
            e3_n   = E_MAX_X;
            f3_n   = F_ONES;
            sat3_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_s     <= 1'b0;
            out_e     <= '0;
            out_f     <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            out_s     <= s2_s;
            out_e     <= e3_n[EXP_W-1:0];
            out_f     <= f3_n;
            out_sat   <= sat3_n;
        end
    end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Randomised and directed bench for fpcvt_pipe, checked against a value-level float model.
module tb_fpcvt_pipe;

`ifdef FPCVT_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_s;
    logic [2:0]  out_e;
    logic [3:0]  out_f;
    logic        out_sat;

    int          n_compared = 0;
    int          n_mismatched = 0;
    bit          ready_random = 1'b0;
    logic [8:0]  exp_q[$];

    always #5 clk = ~clk;

    fpcvt_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_e     (out_e),
        .out_f     (out_f),
        .out_sat   (out_sat)
    );

    // Value-level model: exponent is how far the leading one sits above the mantissa field
    function automatic logic [8:0] model(input logic [11:0] d);
        int   mag, p, e, f, r;
        logic s, sat;
        s   = d[11];
        mag = s ? 4096 - int'(d) : int'(d);
        p   = -1;
        for (int i = 0; i < 12; i++) begin
            if (((mag >> i) & 1) == 1) p = i;
        end
        e = p - 3;
        if (e <= 0) begin
            e = 0;
            f = mag;
            r = 0;
        end else begin
            f = mag >> e;
            r = (mag >> (e - 1)) & 1;
        end
        if (ROUND_EN && r == 1) begin
            f = f + 1;
            if (f == 16) begin
                f = 8;
                e = e + 1;
            end
        end
        sat = (d == 12'h800) || (e > 7);
        if (sat) begin
            e = 7;
            f = 15;
        end
        return {s, 3'(e), 4'(f), sat};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: wait bound expired or unexpected event", name);
    endtask

    // Single compare process: scoreboard, ordering and hold-stability
    logic       hold_prev = 1'b0;
    logic [8:0] held = '0;
    always @(negedge clk) begin : compare_proc
        logic [8:0] cur;
        cur = {out_s, out_e, out_f, out_sat};
        if (hold_prev) checkOutput("hold_stable", 32'(cur), 32'(held));
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) failNow("unexpected_output");
                else checkOutput("result", 32'(cur), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
        end
        hold_prev = !rst && out_valid && !out_ready;
        held      = cur;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_random) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Must be called at posedge+1 so the sample is offered to exactly one accept edge
    task automatic applyStimulus(input logic [11:0] d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready || rst) begin
            waited++;
            if (waited > 200) begin
                failNow("accept_timeout");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitOutValid(output int cycles, output logic [8:0] res);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!out_valid && cycles < 20);
        res = {out_s, out_e, out_f, out_sat};
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_outputs", 32'({out_s, out_e, out_f, out_sat}), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        int c;
        ready_random = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(posedge clk);
            c++;
        end
        idle(5);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    logic [11:0] dir_in[6];
    logic [8:0]  dir_exp[6];

    initial begin
        int         lat;
        logic [8:0] res;

        dir_in[0] = 12'h000; dir_exp[0] = 9'b0_000_0000_0;
        dir_in[1] = 12'h07D; dir_exp[1] = ROUND_EN ? 9'b0_100_1000_0 : 9'b0_011_1111_0;
        dir_in[2] = 12'h800; dir_exp[2] = 9'b1_111_1111_1;
        dir_in[3] = 12'h7FF; dir_exp[3] = ROUND_EN ? 9'b0_111_1111_1 : 9'b0_111_1111_0;
        dir_in[4] = 12'hFFF; dir_exp[4] = 9'b1_000_0001_0;
        dir_in[5] = 12'h00F; dir_exp[5] = 9'b0_000_1111_0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset();
        @(posedge clk);
        #1;

        $display("[TB] directed conversions and latency");
        for (int i = 0; i < 6; i++) begin
            checkOutput("model_pin", 32'(model(dir_in[i])), 32'(dir_exp[i]));
            applyStimulus(dir_in[i]);
            waitOutValid(lat, res);
            checkOutput("latency", 32'(lat), 32'd3);
            checkOutput("direct", 32'(res), 32'(dir_exp[i]));
        end
        drain();

        $display("[TB] stream with downstream stall");
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(12'($urandom));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] reset with samples in flight");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(12'($urandom));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkReset();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(12'h07D);
        waitOutValid(lat, res);
        checkOutput("post_rst_latency", 32'(lat), 32'd3);
        checkOutput("post_rst_result", 32'(res), 32'(dir_exp[1]));
        drain();

        $display("[TB] randomised traffic");
        ready_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [11:0] d;
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 7) == 0) d = dir_in[$urandom_range(0, 5)];
            else d = 12'($urandom);
            applyStimulus(d);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
